// File: rtl/zext_accum_ctrl_pkg.sv
// Shared definitions for the zero-extending block accumulator:
// controller state encoding and the extended-sample width.
package zext_accum_ctrl_pkg;

  localparam int EXT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/zext_accum_ctrl_zext.sv
// ZeroExtend2to3: widens an unsigned 2-bit sample to the extended-sample width.
module ZeroExtend2to3
  import zext_accum_ctrl_pkg::*;
(
  input  logic [1:0]       din_i,
  output logic [EXT_W-1:0] dout_o
);

  assign dout_o = {1'b0, din_i};

endmodule

// File: rtl/zext_accum_ctrl.sv
// Accumulates COUNT zero-extended 2-bit samples per start request and
// presents the modulo-2^SUM_W sum on a valid/ready output handshake.
module zext_accum_ctrl
  import zext_accum_ctrl_pkg::*;
#(
  parameter int COUNT = 4,
  parameter int SUM_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             busy
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  state_t           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EXT_W-1:0] ext;
  logic [SUM_W-1:0] acc_add;
  logic             accept;

  ZeroExtend2to3 u_zext (
    .din_i  (in_data),
    .dout_o (ext)
  );

  // Handshake outputs decode registered state only; no path from in_valid.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_sum   = sum_q;

  assign accept  = in_ready & in_valid;
  assign acc_add = acc_q + SUM_W'(ext);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d = acc_add;
          cnt_d = cnt_q + 1'b1;
          // Final sample: latch the sum including it and stop accepting.
          if (cnt_q == LAST) begin
            sum_d   = acc_add;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_zext_accum_ctrl.sv
// Directed bench for zext_accum_ctrl: two instances (SUM_W=5 and SUM_W=3)
// share stimulus; a scoreboard queue per instance checks every result handshake.
module tb_zext_accum_ctrl;

  localparam int COUNT = 4;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, out_ready;
  logic [1:0] in_data;

  logic       in_ready_a, out_valid_a, busy_a;
  logic [4:0] out_sum_a;
  logic       in_ready_b, out_valid_b, busy_b;
  logic [2:0] out_sum_b;

  int n_tests = 0;
  int n_fail  = 0;
  int q_a[$];
  int q_b[$];

  always #5 clk = ~clk;

  zext_accum_ctrl #(.COUNT(COUNT), .SUM_W(5)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .busy(busy_a)
  );

  zext_accum_ctrl #(.COUNT(COUNT), .SUM_W(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic ir, input logic ov, input logic bz);
    chk({tag, ".a.in_ready"},  {31'd0, in_ready_a},  {31'd0, ir});
    chk({tag, ".a.out_valid"}, {31'd0, out_valid_a}, {31'd0, ov});
    chk({tag, ".a.busy"},      {31'd0, busy_a},      {31'd0, bz});
    chk({tag, ".b.in_ready"},  {31'd0, in_ready_b},  {31'd0, ir});
    chk({tag, ".b.out_valid"}, {31'd0, out_valid_b}, {31'd0, ov});
    chk({tag, ".b.busy"},      {31'd0, busy_b},      {31'd0, bz});
  endtask

  task automatic sum(input string tag, input int e);
    chk({tag, ".a.out_sum"}, {27'd0, out_sum_a}, e % 32);
    chk({tag, ".b.out_sum"}, {29'd0, out_sum_b}, e % 8);
  endtask

  task automatic push(input int e);
    q_a.push_back(e % 32);
    q_b.push_back(e % 8);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  // One accepted sample; in_data is then scrambled to show it is ignored when idle.
  task automatic samp(input logic [1:0] d, input string tag);
    in_valid = 1'b1;
    in_data  = d;
    nedge();
    ctl(tag, 1'b1, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    in_data  = 2'b11;
  endtask

  // Scoreboard: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready) begin
      n_tests++;
      assert (q_a.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_a_unexpected: observed result %0d expected none", out_sum_a);
      end
      if (q_a.size() > 0) begin
        int e;
        e = q_a.pop_front();
        n_tests++;
        assert (out_sum_a === e[4:0]) else begin
          n_fail++;
          $error("FAIL sb_a_sum: observed %0d expected %0d", out_sum_a, e);
        end
      end
    end
    if (!rst && out_valid_b && out_ready) begin
      n_tests++;
      assert (q_b.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_b_unexpected: observed result %0d expected none", out_sum_b);
      end
      if (q_b.size() > 0) begin
        int e;
        e = q_b.pop_front();
        n_tests++;
        assert (out_sum_b === e[2:0]) else begin
          n_fail++;
          $error("FAIL sb_b_sum: observed %0d expected %0d", out_sum_b, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 2'b00; out_ready = 1'b0;
    repeat (3) step();
    nedge();
    ctl("reset", 1'b0, 1'b0, 1'b0);
    sum("reset", 0);
    step();
    rst = 1'b0;

    // Back-to-back samples 0,1,2,3 -> 6, valid the cycle after the 4th.
    start = 1'b1;
    step();
    start = 1'b0;
    samp(2'd0, "s1_0");
    samp(2'd1, "s1_1");
    samp(2'd2, "s1_2");
    push(6);
    samp(2'd3, "s1_3");
    out_ready = 1'b1;
    nedge();
    ctl("s1_done", 1'b0, 1'b1, 1'b1);
    sum("s1_done", 6);
    step();
    out_ready = 1'b0;
    nedge();
    ctl("s1_idle", 1'b0, 1'b0, 1'b0);
    step();

    // 3 x4 with two-cycle gaps -> 12 (wraps to 4 at SUM_W=3).
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push(12);
      samp(2'd3, "s2_samp");
      if (i < 3) begin
        repeat (2) begin
          nedge();
          ctl("s2_gap", 1'b1, 1'b0, 1'b1);
          step();
        end
      end
    end

    // Result held while out_ready low; start pulses in DONE ignored.
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      nedge();
      ctl("s3_hold", 1'b0, 1'b1, 1'b1);
      sum("s3_hold", 12);
      step();
    end
    out_ready = 1'b1;
    start = 1'b1;
    nedge();
    ctl("s3_hs", 1'b0, 1'b1, 1'b1);
    step();
    out_ready = 1'b0;
    start = 1'b0;
    nedge();
    ctl("s3_idle", 1'b0, 1'b0, 1'b0);
    step();
    nedge();
    ctl("s3_idle2", 1'b0, 1'b0, 1'b0);
    step();

    // Reset after two acceptances discards the block; out_sum cleared.
    start = 1'b1;
    step();
    start = 1'b0;
    samp(2'd3, "s4_pre0");
    samp(2'd3, "s4_pre1");
    rst = 1'b1;
    step();
    rst = 1'b0;
    nedge();
    ctl("s4_rst", 1'b0, 1'b0, 1'b0);
    sum("s4_rst", 0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push(4);
      samp(2'd1, "s4_samp");
    end
    out_ready = 1'b1;
    nedge();
    ctl("s4_done", 1'b0, 1'b1, 1'b1);
    sum("s4_done", 4);
    step();
    out_ready = 1'b0;

    // start held high: one block per IDLE entry, never restarted in ACCUM.
    start = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push(8);
      samp(2'd2, "s5_samp");
    end
    out_ready = 1'b1;
    nedge();
    ctl("s5_done", 1'b0, 1'b1, 1'b1);
    step();
    out_ready = 1'b0;
    nedge();
    ctl("s5_idle", 1'b0, 1'b0, 1'b0);
    step();
    nedge();
    ctl("s5_restart", 1'b1, 1'b0, 1'b1);
    step();
    nedge();
    ctl("s5_hold_accum", 1'b1, 1'b0, 1'b1);
    step();
    samp(2'd1, "s5b_0");
    start = 1'b0;
    samp(2'd1, "s5b_1");
    samp(2'd1, "s5b_2");
    push(4);
    samp(2'd1, "s5b_3");
    out_ready = 1'b1;
    nedge();
    ctl("s5b_done", 1'b0, 1'b1, 1'b1);
    sum("s5b_done", 4);
    step();
    out_ready = 1'b0;
    nedge();
    ctl("s5b_idle", 1'b0, 1'b0, 1'b0);

    chk("sb_a_drained", q_a.size(), 0);
    chk("sb_b_drained", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zext_accum_ctrl.md
ZEXT_ACCUM_CTRL -- requirements
Module: zext_accum_ctrl

Interface
REQ-001 The block SHALL have parameter COUNT, default 4, number of 2-bit samples per block (COUNT >= 1).
REQ-002 The block SHALL have parameter SUM_W, default 5, accumulator/result width (SUM_W >= 3).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, single-cycle request to begin one block.
REQ-007 The block SHALL have port in_valid, input, 1, sample present on in_data.
REQ-008 The block SHALL have port in_ready, output, 1, block accepts a sample this cycle.
REQ-009 The block SHALL have port in_data, input, 2, unsigned sample.
REQ-010 The block SHALL have port out_valid, output, 1, out_sum holds a completed result.
REQ-011 The block SHALL have port out_ready, input, 1, consumer takes the result.
REQ-012 The block SHALL have port out_sum, output, SUM_W, accumulated result.
REQ-013 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-015 In IDLE, start=1 SHALL clear the accumulator and sample counter and move to ACCUM on the next edge; start SHALL be ignored in ACCUM and DONE.
REQ-016 in_ready SHALL be a registered-state decode equal to 1 only in ACCUM, with no combinational path from in_valid.
REQ-017 A sample SHALL be accepted only on a cycle where in_valid=1 and in_ready=1; in_data SHALL be ignored otherwise.
REQ-018 Each accepted sample SHALL be zero-extended to 3 bits ({0,in_data}), then to SUM_W, and added to the accumulator modulo 2^SUM_W, with no saturation.
REQ-019 The sample counter SHALL increment per accepted sample; on the COUNT-th acceptance the FSM SHALL go to DONE, latching the final sum including that sample.
REQ-020 out_valid SHALL rise on the cycle after the final acceptance (one-cycle latency), with no further samples accepted in that cycle or after it.
REQ-021 In DONE, out_valid=1 and out_sum SHALL stay stable until out_ready=1; on that handshake cycle the FSM SHALL return to IDLE and out_valid SHALL fall on the next edge.
REQ-022 A start pulse in the DONE handshake cycle SHALL be ignored; a new block requires start while in IDLE.
REQ-023 For COUNT=1, a single acceptance SHALL complete the block.
REQ-024 Gaps in in_valid during ACCUM SHALL stall accumulation indefinitely with no timeout.
REQ-025 out_sum SHALL hold its last value in IDLE and ACCUM and SHALL be meaningful only while out_valid=1.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL enter IDLE and clear the accumulator, counter and out_sum to 0.
REQ-027 Reset SHALL take priority over all inputs, including start and both handshakes.
REQ-028 Reset SHALL force out_valid=0, in_ready=0 and busy=0 from the following cycle.
REQ-029 Reset asserted mid-ACCUM or mid-DONE SHALL discard the partial or pending result.

Structure
REQ-030 The state encoding and the 3-bit extended-sample width constant SHALL live in the shared project package/header.
REQ-031 The zero-extension SHALL instantiate the existing ZeroExtend2to3 sub-module; accumulator, counter and FSM SHALL reside in zext_accum_ctrl.
REQ-032 The counter width SHALL be derived from COUNT as $clog2(COUNT+1).

Verification (COUNT=4, SUM_W=5)
REQ-033 The bench SHALL cover: start, then back-to-back samples 00,01,10,11 -> out_valid one cycle after 4th acceptance, out_sum=6.
REQ-034 The bench SHALL cover: samples 11 x4 with in_valid low 2 cycles between each -> out_sum=12; in_ready stays 1 throughout ACCUM.
REQ-035 The bench SHALL cover: result ready with out_ready low 5 cycles -> out_valid and out_sum=12 held; the start pulses inside DONE are ignored; IDLE is reached after the handshake.
REQ-036 The bench SHALL cover: rst pulsed after 2 acceptances -> IDLE, busy=0; then a new block 01 x4 -> out_sum=4.
REQ-037 The bench SHALL cover: SUM_W=3 with samples 11 x4 -> out_sum=12 mod 8 = 4 (wrap).
REQ-038 The bench SHALL cover: start held high across a completed block -> exactly one new block begins per IDLE entry.
